// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
//   ADDR_W / DATA_W / NUM_REGS / ZERO_R0 : default geometry and R0 policy
//   arbState_t : sequencer states (clear sweep, normal run)
//   writeReq_t : one write request / write-port beat {valid, addr, data}
//   rrGrant()  : two-way round-robin grant, prio selects the winner on contention
package regfile_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;
    localparam int ZERO_R0  = 1;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } arbState_t;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } writeReq_t;

    function automatic logic [1:0] rrGrant(input logic [1:0] valid, input logic prio);
        if (valid == 2'b11) begin
            return prio ? 2'b10 : 2'b01;
        end
        return valid;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus bundle between the two writeback requesters and the register file write port.
//   req0_* : ALU writeback request (valid/addr/data in, ready out)
//   req1_* : load writeback request (valid/addr/data in, ready out)
//   reg_write / WriteAddr / WriteData : registered write port towards RegisterFile
//   busy      : clear sweep in progress, no requests accepted
//   stall_cnt : saturating count of refused-request cycles
// modport master = requester/observer side, modport slave = arbiter side.
interface regfile_write_arbiter_if #(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              reg_write;
    logic [ADDR_W-1:0] WriteAddr;
    logic [DATA_W-1:0] WriteData;
    logic              busy;
    logic [15:0]       stall_cnt;

    modport master (
        output req0_valid, req0_addr, req0_data,
        output req1_valid, req1_addr, req1_data,
        input  req0_ready, req1_ready,
        input  reg_write, WriteAddr, WriteData, busy, stall_cnt
    );

    modport slave (
        input  req0_valid, req0_addr, req0_data,
        input  req1_valid, req1_addr, req1_data,
        output req0_ready, req1_ready,
        output reg_write, WriteAddr, WriteData, busy, stall_cnt
    );
endinterface

// File: rtl/regfile_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with its priority flop.
//   clka, rst : clock, synchronous active-high reset (prio -> 0, req0 first)
//   enable    : grants allowed (low while the clear sweep owns the port)
//   valid     : request bits {req1, req0}
//   grant     : one-hot grant, combinational from valid and prio
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clka,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic prio;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            grant = rrGrant(valid, prio);
        end
    end

    // After any grant the other requester wins the next tie; grant[0] set means req1 lost.
    always_ff @(posedge clka) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (|grant) begin
            prio <= grant[0];
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between ALU writeback (req0) and load
// writeback (req1). One registered write per cycle, round-robin on contention.
//   clka : clock, all logic on posedge
//   rst  : synchronous active-high reset
//   bus  : regfile_write_arbiter_if.slave (requests, readys, write port, busy, stall_cnt)
// Build option REGFILE_ARB_CLEAR_EN: after reset, sweep zeros into regs 0..NUM_REGS-1
// before accepting requests. Without it the block runs from the first post-reset cycle.
//
// state    | meaning
// ST_CLEAR | zero sweep in progress, readys forced 0, busy=1
// ST_RUN   | normal arbitration, terminal until reset
module regfile_write_arbiter
    import regfile_pkg::arbState_t, regfile_pkg::ST_CLEAR, regfile_pkg::ST_RUN;
#(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int ZERO_R0  = regfile_pkg::ZERO_R0
) (
    input logic                  clka,
    input logic                  rst,
    regfile_write_arbiter_if.slave bus
);

    logic [1:0]        grant;
    logic              runEn;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selData;
    logic              refused;
    logic              suppress;

    logic              regWrite;
    logic [ADDR_W-1:0] writeAddr;
    logic [DATA_W-1:0] writeData;
    logic [15:0]       stallCnt;

`ifdef REGFILE_ARB_CLEAR_EN
    localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(NUM_REGS - 1);
    arbState_t         state;
    logic [ADDR_W-1:0] sweepLeft;

    assign runEn = (state == ST_RUN);
`else
    assign runEn = 1'b1;
`endif

    rr_arb2 uArb (
        .clka   (clka),
        .rst    (rst),
        .enable (runEn),
        .valid  ({bus.req1_valid, bus.req0_valid}),
        .grant  (grant)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign bus.busy       = ~runEn;
    assign bus.reg_write  = regWrite;
    assign bus.WriteAddr  = writeAddr;
    assign bus.WriteData  = writeData;
    assign bus.stall_cnt  = stallCnt;

    assign selAddr  = grant[1] ? bus.req1_addr : bus.req0_addr;
    assign selData  = grant[1] ? bus.req1_data : bus.req0_data;
    assign suppress = (ZERO_R0 != 0) && (selAddr == '0);
    // In RUN at most one requester can be refused, so a single increment suffices.
    assign refused  = runEn & ((bus.req0_valid & ~grant[0]) | (bus.req1_valid & ~grant[1]));

    always_ff @(posedge clka) begin
        if (rst) begin
            regWrite  <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
            stallCnt  <= '0;
`ifdef REGFILE_ARB_CLEAR_EN
            state     <= ST_CLEAR;
            sweepLeft <= SWEEP_LAST;
`endif
        end else begin
`ifdef REGFILE_ARB_CLEAR_EN
            if (state == ST_CLEAR) begin
                // Down-counter; the sweep address counts up from 0.
                regWrite  <= 1'b1;
                writeAddr <= SWEEP_LAST - sweepLeft;
                writeData <= '0;
                if (sweepLeft == '0) begin
                    state <= ST_RUN;
                end else begin
                    sweepLeft <= sweepLeft - 1'b1;
                end
            end else
`endif
            begin
                if (|grant) begin
                    regWrite  <= ~suppress;
                    writeAddr <= selAddr;
                    writeData <= selData;
                end else begin
                    regWrite  <= 1'b0;
                end
                if (refused && (stallCnt != 16'hFFFF)) begin
                    stallCnt <= stallCnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Self-checking bench for regfile_write_arbiter. Expected write-port beats are pushed to a
// scoreboard queue by a behavioural model as each cycle is driven, then popped and compared
// against the DUT one cycle later. Clear-sweep tests run only with REGFILE_ARB_CLEAR_EN.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    typedef struct packed {
        logic              v0;
        logic [ADDR_W-1:0] a0;
        logic [DATA_W-1:0] d0;
        logic              v1;
        logic [ADDR_W-1:0] a1;
        logic [DATA_W-1:0] d1;
    } stim_t;

    logic clka = 1'b0;
    logic rst  = 1'b1;

    always #5 clka = ~clka;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter dut (
        .clka (clka),
        .rst  (rst),
        .bus  (bus)
    );

    int checks = 0;
    int fails  = 0;

    // Behavioural model state
    logic              mPrio;
    int                mStall;
    logic [ADDR_W-1:0] mAddr;
    logic [DATA_W-1:0] mData;
    writeReq_t         sb[$];

`ifdef REGFILE_ARB_CLEAR_EN
    localparam logic EXP_BUSY_AFTER_RST = 1'b1;
`else
    localparam logic EXP_BUSY_AFTER_RST = 1'b0;
`endif

    task automatic model_reset();
        mPrio  = 1'b0;
        mStall = 0;
        mAddr  = '0;
        mData  = '0;
        sb.delete();
    endtask

    task automatic model_cycle(input stim_t s, output logic r0, output logic r1);
        writeReq_t e;
        r0 = 1'b0;
        r1 = 1'b0;
        if (s.v0 && s.v1) begin
            if (mPrio) r1 = 1'b1;
            else       r0 = 1'b1;
        end else begin
            r0 = s.v0;
            r1 = s.v1;
        end
        if ((s.v0 && !r0) || (s.v1 && !r1)) begin
            if (mStall < 65535) mStall++;
        end
        if (r0 || r1) begin
            mAddr   = r1 ? s.a1 : s.a0;
            mData   = r1 ? s.d1 : s.d0;
            e.valid = !((ZERO_R0 != 0) && (mAddr == '0));
            mPrio   = r0;
        end else begin
            e.valid = 1'b0;
        end
        e.addr = mAddr;
        e.data = mData;
        sb.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        bus.req0_valid = s.v0;
        bus.req0_addr  = s.a0;
        bus.req0_data  = s.d0;
        bus.req1_valid = s.v1;
        bus.req1_addr  = s.a1;
        bus.req1_data  = s.d1;
    endtask

    // Drives one cycle, samples readys mid-cycle and the write port after the next edge.
    task automatic run_cycle(input stim_t s, output logic er0, output logic er1,
                             output logic gr0, output logic gr1,
                             output writeReq_t exp, output writeReq_t got);
        drive(s);
        @(negedge clka);
        gr0 = bus.req0_ready;
        gr1 = bus.req1_ready;
        model_cycle(s, er0, er1);
        @(posedge clka);
        #1;
        exp       = sb.pop_front();
        got.valid = bus.reg_write;
        got.addr  = bus.WriteAddr;
        got.data  = bus.WriteData;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive('0);
        @(posedge clka);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if (bus.reg_write !== 1'b0) begin
            fails++; $display("FAIL reset_reg_write: got %b expected 0", bus.reg_write);
        end
        checks++;
        if (bus.WriteAddr !== '0 || bus.WriteData !== '0) begin
            fails++; $display("FAIL reset_addr_data: got %h/%h expected 0/0", bus.WriteAddr, bus.WriteData);
        end
        checks++;
        if (bus.stall_cnt !== 16'h0) begin
            fails++; $display("FAIL reset_stall_cnt: got %h expected 0", bus.stall_cnt);
        end
        checks++;
        if (bus.busy !== EXP_BUSY_AFTER_RST) begin
            fails++; $display("FAIL reset_busy: got %b expected %b", bus.busy, EXP_BUSY_AFTER_RST);
        end
    endtask

`ifdef REGFILE_ARB_CLEAR_EN
    // Entered in the first cycle after reset deasserts. Requests are held valid while the
    // sweep runs and must be ignored.
    task automatic test_clear_sweep();
        for (int k = 0; k <= NUM_REGS; k++) begin
            if (k >= 1) begin
                checks++;
                if (bus.reg_write !== 1'b1 || bus.WriteAddr !== ADDR_W'(k - 1) || bus.WriteData !== '0) begin
                    fails++;
                    $display("FAIL sweep_write_%0d: got we=%b addr=%0d data=%h expected we=1 addr=%0d data=0",
                             k - 1, bus.reg_write, bus.WriteAddr, bus.WriteData, k - 1);
                end
            end
            if (k < NUM_REGS) begin
                drive('{v0: 1'b1, a0: 5'd3, d0: 32'hDEAD0003, v1: 1'b1, a1: 5'd4, d1: 32'hDEAD0004});
                @(negedge clka);
                checks++;
                if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || bus.busy !== 1'b1) begin
                    fails++;
                    $display("FAIL sweep_ready_busy_%0d: got r0=%b r1=%b busy=%b expected 0 0 1",
                             k, bus.req0_ready, bus.req1_ready, bus.busy);
                end
            end else begin
                drive('0);
                @(negedge clka);
                checks++;
                if (bus.busy !== 1'b0) begin
                    fails++; $display("FAIL sweep_done_busy: got %b expected 0", bus.busy);
                end
            end
            @(posedge clka);
            #1;
        end
        checks++;
        if (bus.reg_write !== 1'b0 || bus.stall_cnt !== 16'h0) begin
            fails++;
            $display("FAIL sweep_after: got we=%b stall=%h expected we=0 stall=0", bus.reg_write, bus.stall_cnt);
        end
        mAddr = ADDR_W'(NUM_REGS - 1);
        mData = '0;
    endtask

    task automatic test_clear();
        apply_reset();
        test_clear_sweep();
    endtask

    task automatic test_reset_mid_sweep();
        apply_reset();
        repeat (11) begin
            @(posedge clka);
            #1;
        end
        checks++;
        if (bus.reg_write !== 1'b1 || bus.WriteAddr !== 5'd10) begin
            fails++; $display("FAIL midsweep_reach10: got we=%b addr=%0d expected 1 10", bus.reg_write, bus.WriteAddr);
        end
        apply_reset();
        checks++;
        if (bus.reg_write !== 1'b0 || bus.WriteAddr !== '0 || bus.busy !== 1'b1 || bus.stall_cnt !== 16'h0) begin
            fails++;
            $display("FAIL midsweep_reset: got we=%b addr=%0d busy=%b stall=%h expected 0 0 1 0",
                     bus.reg_write, bus.WriteAddr, bus.busy, bus.stall_cnt);
        end
        test_clear_sweep();
    endtask
`endif

    task automatic skip_clear();
`ifdef REGFILE_ARB_CLEAR_EN
        repeat (NUM_REGS + 1) begin
            @(posedge clka);
            #1;
        end
        mAddr = ADDR_W'(NUM_REGS - 1);
        mData = '0;
`endif
    endtask

    task automatic test_contention();
        logic er0, er1, gr0, gr1;
        writeReq_t exp, got;
        stim_t s;
        s = '{v0: 1'b1, a0: 5'd1, d0: 32'h0000_0011, v1: 1'b1, a1: 5'd2, d1: 32'h0000_0022};
        for (int k = 0; k < 4; k++) begin
            run_cycle(s, er0, er1, gr0, gr1, exp, got);
            checks++;
            if ({gr1, gr0} !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin
                fails++; $display("FAIL contention_grant_%0d: got %b expected %b", k, {gr1, gr0},
                                  (k % 2 == 0) ? 2'b01 : 2'b10);
            end
            checks++;
            if (got !== exp) begin
                fails++; $display("FAIL contention_write_%0d: got %h expected %h", k, got, exp);
            end
        end
        checks++;
        if (bus.stall_cnt !== 16'd4) begin
            fails++; $display("FAIL contention_stall_cnt: got %0d expected 4", bus.stall_cnt);
        end
    endtask

    task automatic test_single();
        logic er0, er1, gr0, gr1;
        writeReq_t exp, got;
        stim_t tbl[3];
        tbl[0] = '{v0: 1'b1, a0: 5'd5, d0: 32'hAAAA_AAAA, v1: 1'b0, a1: 5'd9, d1: 32'h0};
        tbl[1] = '{v0: 1'b0, a0: 5'd6, d0: 32'h0,         v1: 1'b0, a1: 5'd9, d1: 32'h0};
        tbl[2] = '{v0: 1'b0, a0: 5'd6, d0: 32'h0,         v1: 1'b1, a1: 5'd7, d1: 32'h5555_5555};
        for (int k = 0; k < 3; k++) begin
            run_cycle(tbl[k], er0, er1, gr0, gr1, exp, got);
            checks++;
            if ({gr1, gr0} !== {er1, er0}) begin
                fails++; $display("FAIL single_ready_%0d: got %b expected %b", k, {gr1, gr0}, {er1, er0});
            end
            checks++;
            if (got !== exp) begin
                fails++; $display("FAIL single_write_%0d: got %h expected %h", k, got, exp);
            end
            if (k == 0) begin
                checks++;
                if (gr0 !== 1'b1 || got.valid !== 1'b1 || got.addr !== 5'd5 || got.data !== 32'hAAAA_AAAA) begin
                    fails++; $display("FAIL single_req0: got r0=%b we=%b addr=%0d data=%h expected 1 1 5 aaaaaaaa",
                                      gr0, got.valid, got.addr, got.data);
                end
            end
            if (k == 1) begin
                checks++;
                if (got.valid !== 1'b0 || got.addr !== 5'd5 || got.data !== 32'hAAAA_AAAA) begin
                    fails++; $display("FAIL single_idle_hold: got we=%b addr=%0d data=%h expected 0 5 aaaaaaaa",
                                      got.valid, got.addr, got.data);
                end
            end
        end
        checks++;
        if (bus.stall_cnt !== mStall[15:0]) begin
            fails++; $display("FAIL single_stall_cnt: got %0d expected %0d", bus.stall_cnt, mStall);
        end
    endtask

    task automatic test_r0();
        logic er0, er1, gr0, gr1;
        writeReq_t exp, got;
        stim_t tbl[2];
        tbl[0] = '{v0: 1'b0, a0: 5'd8, d0: 32'h0,         v1: 1'b1, a1: 5'd0, d1: 32'h0000_1234};
        tbl[1] = '{v0: 1'b1, a0: 5'd8, d0: 32'h0000_0088, v1: 1'b1, a1: 5'd9, d1: 32'h0000_0099};
        for (int k = 0; k < 2; k++) begin
            run_cycle(tbl[k], er0, er1, gr0, gr1, exp, got);
            checks++;
            if ({gr1, gr0} !== {er1, er0}) begin
                fails++; $display("FAIL r0_ready_%0d: got %b expected %b", k, {gr1, gr0}, {er1, er0});
            end
            checks++;
            if (got.valid !== exp.valid || (exp.valid && got !== exp)) begin
                fails++; $display("FAIL r0_write_%0d: got %h expected %h", k, got, exp);
            end
        end
        checks++;
        if (bus.stall_cnt !== mStall[15:0]) begin
            fails++; $display("FAIL r0_stall_cnt: got %0d expected %0d", bus.stall_cnt, mStall);
        end
    endtask

    task automatic test_saturation();
        logic er0, er1, gr0, gr1;
        writeReq_t exp, got;
        stim_t s;
        s = '{v0: 1'b1, a0: 5'd12, d0: 32'h0000_00C0, v1: 1'b1, a1: 5'd13, d1: 32'h0000_00D0};
        drive(s);
        for (int k = 0; k < 70000; k++) begin
            @(posedge clka);
            mPrio = ~mPrio;
        end
        #1;
        mStall = 65535;
        mAddr  = mPrio ? s.a0 : s.a1;
        mData  = mPrio ? s.d0 : s.d1;
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin
            fails++; $display("FAIL sat_stall_cnt: got %h expected ffff", bus.stall_cnt);
        end
        run_cycle(s, er0, er1, gr0, gr1, exp, got);
        checks++;
        if ({gr1, gr0} !== {er1, er0} || got !== exp) begin
            fails++; $display("FAIL sat_after_cycle: got %b/%h expected %b/%h", {gr1, gr0}, got, {er1, er0}, exp);
        end
        checks++;
        if (bus.stall_cnt !== 16'hFFFF) begin
            fails++; $display("FAIL sat_stall_hold: got %h expected ffff", bus.stall_cnt);
        end
    endtask

    // Leaves prio pointing at req1, resets, and confirms req0 wins the first tie again.
    task automatic test_reset_restart();
        logic er0, er1, gr0, gr1;
        writeReq_t exp, got;
        run_cycle('{v0: 1'b1, a0: 5'd14, d0: 32'h0000_00E0, v1: 1'b0, a1: 5'd0, d1: 32'h0},
                  er0, er1, gr0, gr1, exp, got);
        apply_reset();
        checks++;
        if (bus.stall_cnt !== 16'h0 || bus.reg_write !== 1'b0) begin
            fails++; $display("FAIL restart_outputs: got stall=%h we=%b expected 0 0", bus.stall_cnt, bus.reg_write);
        end
        skip_clear();
        run_cycle('{v0: 1'b1, a0: 5'd20, d0: 32'h0000_0200, v1: 1'b1, a1: 5'd21, d1: 32'h0000_0210},
                  er0, er1, gr0, gr1, exp, got);
        checks++;
        if ({gr1, gr0} !== 2'b01 || got.addr !== 5'd20) begin
            fails++; $display("FAIL restart_prio: got grant=%b addr=%0d expected 01 20", {gr1, gr0}, got.addr);
        end
    endtask

    initial begin
        drive('0);
        test_reset();
`ifdef REGFILE_ARB_CLEAR_EN
        test_clear();
`endif
        test_contention();
        test_single();
        test_r0();
`ifdef REGFILE_ARB_CLEAR_EN
        test_reset_mid_sweep();
`endif
        test_saturation();
        test_reset_restart();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
